// File: rtl/cache_pkg.sv
// Shared definitions for the cache line path. The cache controller, the main
// memory model and the line sequencer all agree on these values.
//   ADDR_W     : memory address width
//   WORD_W     : bits per memory word (one beat)
//   LINE_WORDS : words per cache line (beats per transfer phase)
//   OFF_W      : log2(LINE_WORDS), the offset bits inside a line address
//   LINE_W     : width of a whole cache line
//   seq_state_t: line sequencer states
package cache_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 8;
    localparam int LINE_WORDS = 8;
    localparam int OFF_W      = 3;
    localparam int LINE_W     = LINE_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Clear the offset bits so that any address inside a line maps to its base.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(LINE_WORDS - 1);
    endfunction

    // Beat address inside an aligned line. The beat index only ever occupies
    // the offset bits, so it can never carry into the tag/index part.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [OFF_W-1:0]  beat);
        return base | ADDR_W'(beat);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
//   clk   : clock
//   clr_i : synchronous clear (active high)
//   inc_i : count one event this cycle
//   cnt_o : registered count, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_line_sequencer.sv
// Whole-line transfer sequencer between the cache controller and byte-wide
// main memory. One accepted job runs an optional victim writeback followed by
// a refill; the refilled line is returned with a one-cycle done pulse.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : job handshake (ready only while idle)
//   req_wb                 : job carries a dirty victim
//   wb_addr, wb_line       : victim line address and data (word k at [8k+7:8k])
//   fill_addr              : refill line address (offset bits ignored)
//   done, fill_line        : completion pulse and refilled line
//   mem_addr/mem_wdata     : beat address and write data
//   mem_we/mem_re          : write/read strobes, held until acknowledged
//   mem_rdata/mem_ack      : read data and beat acknowledge
//   fill_cnt, wb_cnt       : saturating completion statistics
module cache_line_sequencer
    import cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_line,
    input  logic [ADDR_W-1:0] fill_addr,
    output logic              done,
    output logic [LINE_W-1:0] fill_line,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  fill_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);

    seq_state_t        state_q,     state_d;
    logic [OFF_W-1:0]  beat_q,      beat_d;
    logic [ADDR_W-1:0] wb_base_q,   wb_base_d;
    logic [ADDR_W-1:0] fill_base_q, fill_base_d;
    logic [LINE_W-1:0] wb_line_q,   wb_line_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;
    logic              mem_re_q,    mem_re_d;
    logic              done_q,      done_d;
    logic              req_ready_q, req_ready_d;

    logic [LINE_WORDS-1:0] fill_we;
    logic                  wb_inc;
    logic                  fill_inc;
    logic                  last_beat;
    logic [OFF_W-1:0]      beat_nxt;

    assign last_beat = (beat_q == OFF_W'(LINE_WORDS - 1));
    assign beat_nxt  = beat_q + OFF_W'(1);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wb_base_d   = wb_base_q;
        fill_base_d = fill_base_q;
        wb_line_d   = wb_line_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_re_d    = mem_re_q;
        fill_we     = '0;
        wb_inc      = 1'b0;
        fill_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wb_base_d   = line_base(wb_addr);
                    fill_base_d = line_base(fill_addr);
                    wb_line_d   = wb_line;
                    beat_d      = '0;
                    if (req_wb) begin
                        state_d     = WB;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = line_base(wb_addr);
                        // First write beat comes straight from the request so
                        // the strobe can go out on the acceptance edge.
                        mem_wdata_d = wb_line[WORD_W-1:0];
                    end else begin
                        state_d    = FILL;
                        mem_re_d   = 1'b1;
                        mem_addr_d = line_base(fill_addr);
                    end
                end
            end

            WB: begin
                if (mem_ack) begin
                    if (last_beat) begin
                        // Hand straight over to the refill: the write strobe
                        // drops on the same edge the read strobe rises.
                        mem_we_d   = 1'b0;
                        wb_inc     = 1'b1;
                        state_d    = FILL;
                        mem_re_d   = 1'b1;
                        beat_d     = '0;
                        mem_addr_d = fill_base_q;
                    end else begin
                        beat_d      = beat_nxt;
                        mem_addr_d  = beat_addr(wb_base_q, beat_nxt);
                        mem_wdata_d = wb_line_q[int'(beat_nxt)*WORD_W +: WORD_W];
                    end
                end
            end

            FILL: begin
                if (mem_ack) begin
                    fill_we[beat_q] = 1'b1;
                    if (last_beat) begin
                        mem_re_d = 1'b0;
                        fill_inc = 1'b1;
                        state_d  = DONE;
                        beat_d   = '0;
                    end else begin
                        beat_d     = beat_nxt;
                        mem_addr_d = beat_addr(fill_base_q, beat_nxt);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered images of the next state.
        req_ready_d = (state_d == IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wb_base_q   <= '0;
            fill_base_q <= '0;
            wb_line_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wb_base_q   <= wb_base_d;
            fill_base_q <= fill_base_d;
            wb_line_q   <= wb_line_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            done_q      <= done_d;
            req_ready_q <= req_ready_d;
        end
    end

    // One register per fill word, each loaded only on its own beat's ack.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_fill
            logic [WORD_W-1:0] word_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_q <= '0;
                end else if (fill_we[gi]) begin
                    word_q <= mem_rdata;
                end
            end

            assign fill_line[gi*WORD_W +: WORD_W] = word_q;
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_fill_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (fill_inc),
        .cnt_o (fill_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (wb_inc),
        .cnt_o (wb_cnt)
    );

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_cache_line_sequencer.sv
// Directed bench for cache_line_sequencer: byte-wide memory model whose read
// word is rd_base + beat offset, optional 3-cycle ack stalls, and logs of
// every acknowledged write/read beat.
module tb_cache_line_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wb;
    logic [31:0] wb_addr;
    logic [63:0] wb_line;
    logic [31:0] fill_addr;
    logic        done;
    logic [63:0] fill_line;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_ack = 1'b0;
    logic [15:0] fill_cnt;
    logic [15:0] wb_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cnt = 0;
    int overlap = 0;
    int hold_cnt = 0;
    int hold_viol = 0;
    int sc = 0;
    int lat;
    int dc;

    logic        ack_tie = 1'b0;
    logic        stall_mode = 1'b0;
    logic [7:0]  rd_base = 8'h10;
    logic [41:0] prev_bus = '0;
    logic        prev_strobe = 1'b0;

    logic [39:0] wr_q[$];
    logic [31:0] rd_q[$];
    int          acc_q[$];

    always #5 clk = ~clk;

    assign mem_rdata = rd_base + {5'b0, mem_addr[2:0]};

    cache_line_sequencer #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wb    (req_wb),
        .wb_addr   (wb_addr),
        .wb_line   (wb_line),
        .fill_addr (fill_addr),
        .done      (done),
        .fill_line (fill_line),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .fill_cnt  (fill_cnt),
        .wb_cnt    (wb_cnt)
    );

    // Edge monitor: values read here are those present just before the edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (mem_ack && mem_we) wr_q.push_back({mem_addr, mem_wdata});
            if (mem_ack && mem_re) rd_q.push_back(mem_addr);
            if (mem_we && mem_re)  overlap++;
            if (done)              done_cnt++;
            if (req_valid && req_ready) acc_q.push_back(cyc + 1);
        end
    end

    // Ack generator plus hold-stability watcher for unacknowledged beats.
    always @(negedge clk) begin
        if (prev_strobe && !mem_ack) begin
            hold_cnt++;
            if ({mem_addr, mem_wdata, mem_we, mem_re} !== prev_bus) hold_viol++;
        end
        prev_bus    = {mem_addr, mem_wdata, mem_we, mem_re};
        prev_strobe = mem_we | mem_re;
        if (stall_mode) begin
            if (mem_we | mem_re) begin
                if (sc == 3) begin
                    mem_ack = 1'b1;
                    sc = 0;
                end else begin
                    mem_ack = 1'b0;
                    sc++;
                end
            end else begin
                mem_ack = 1'b0;
                sc = 0;
            end
        end else begin
            mem_ack = ack_tie;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while req_ready is high; returns at the negedge
    // right after the acceptance edge with t0 marking that edge.
    task automatic start_job(input logic wb, input logic [31:0] wa,
                             input logic [63:0] wl, input logic [31:0] fa);
        wr_q.delete();
        rd_q.delete();
        req_wb    = wb;
        wb_addr   = wa;
        wb_line   = wl;
        fill_addr = fa;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                l = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wb    = 1'b0;
        wb_addr   = '0;
        wb_line   = '0;
        fill_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", req_ready, 1);
        check("rst_done", done, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_fill_line", fill_line, 0);
        check("rst_fill_cnt", fill_cnt, 0);
        check("rst_wb_cnt", wb_cnt, 0);

        // Ack with no request has no effect
        ack_tie = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_ready", req_ready, 1);
        check("idle_strobes", {mem_we, mem_re}, 0);
        check("idle_addr", mem_addr, 0);
        check("idle_cnt", {fill_cnt, wb_cnt}, 0);
        check("idle_done_cnt", done_cnt, 0);

        // Clean fill, ack tied high
        start_job(1'b0, 32'h0, 64'h0, 32'h0000_0028);
        wait_done(lat);
        check("clean_latency", lat, 8);
        check("clean_line", fill_line, 64'h1716151413121110);
        check("clean_fill_cnt", fill_cnt, 1);
        check("clean_wb_cnt", wb_cnt, 0);
        check("clean_reads", rd_q.size(), 8);
        check("clean_writes", wr_q.size(), 0);
        for (int i = 0; i < 8; i++)
            if (i < rd_q.size()) check($sformatf("clean_raddr%0d", i), rd_q[i], 32'h28 + i);
        check("clean_ready_in_done", req_ready, 0);
        @(negedge clk);
        check("clean_done_width", done, 0);
        check("clean_ready_back", req_ready, 1);
        check("clean_done_pulses", done_cnt, 1);

        // Dirty job: writeback then refill
        start_job(1'b1, 32'h0000_0048, 64'h0807060504030201, 32'h0000_0028);
        wait_done(lat);
        check("dirty_latency", lat, 16);
        check("dirty_writes", wr_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < wr_q.size())
                check($sformatf("dirty_wbeat%0d", i), wr_q[i], {32'h48 + i, 8'(i + 1)});
        check("dirty_reads", rd_q.size(), 8);
        if (rd_q.size() == 8) begin
            check("dirty_raddr0", rd_q[0], 32'h28);
            check("dirty_raddr7", rd_q[7], 32'h2F);
        end
        check("dirty_line", fill_line, 64'h1716151413121110);
        check("dirty_wb_cnt", wb_cnt, 1);
        check("dirty_fill_cnt", fill_cnt, 2);
        @(negedge clk);

        // Stalled beats: three idle cycles before each ack
        stall_mode = 1'b1;
        hold_cnt = 0;
        hold_viol = 0;
        @(negedge clk);
        start_job(1'b0, 32'h0, 64'h0, 32'h0000_0028);
        wait_done(lat);
        check("stall_latency", lat, 32);
        check("stall_line", fill_line, 64'h1716151413121110);
        check("stall_holds", hold_cnt, 24);
        check("stall_hold_viol", hold_viol, 0);
        check("stall_fill_cnt", fill_cnt, 3);
        check("stall_reads", rd_q.size(), 8);
        stall_mode = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset after four write beats
        start_job(1'b1, 32'h0000_0048, 64'h0807060504030201, 32'h0000_0028);
        for (int i = 0; i < 50; i++) begin
            if (wr_q.size() >= 4) break;
            @(negedge clk);
        end
        check("abort_wbeats", wr_q.size(), 4);
        rst = 1'b1;
        dc = done_cnt;
        @(negedge clk);
        check("abort_we", mem_we, 0);
        check("abort_re", mem_re, 0);
        check("abort_done", done, 0);
        check("abort_line", fill_line, 0);
        check("abort_cnt", {fill_cnt, wb_cnt}, 0);
        check("abort_ready", req_ready, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        check("abort_no_more_writes", wr_q.size(), 4);

        // Recovery job; unaligned fill address uses line base 0x28
        rd_base = 8'h30;
        start_job(1'b0, 32'h0, 64'h0, 32'h0000_002D);
        wait_done(lat);
        check("recover_latency", lat, 8);
        check("recover_line", fill_line, 64'h3736353433323130);
        if (rd_q.size() == 8) begin
            check("recover_raddr0", rd_q[0], 32'h28);
            check("recover_raddr7", rd_q[7], 32'h2F);
        end else begin
            check("recover_reads", rd_q.size(), 8);
        end
        check("recover_cnt", {fill_cnt, wb_cnt}, {16'd1, 16'd0});
        @(negedge clk);

        // Saturation: preload the fill counter near full
        rd_base = 8'h10;
        force dut.u_fill_cnt.cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.u_fill_cnt.cnt_q;
        @(negedge clk);
        check("sat_preload", fill_cnt, 16'hFFFE);
        start_job(1'b0, 32'h0, 64'h0, 32'h0000_0028);
        wait_done(lat);
        check("sat_first", fill_cnt, 16'hFFFF);
        @(negedge clk);

        // Back-to-back with req_valid held high
        acc_q.delete();
        dc = done_cnt;
        req_wb    = 1'b0;
        fill_addr = 32'h0000_0028;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done_cnt - dc >= 2) break;
            if (done) check("b2b_ready_in_done", req_ready, 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_done_pulses", done_cnt - dc, 2);
        check("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() == 2) check("b2b_accept_gap", acc_q[1] - acc_q[0], 10);
        check("b2b_fill_sat", fill_cnt, 16'hFFFF);
        check("b2b_wb_cnt", wb_cnt, 0);
        check("b2b_line", fill_line, 64'h1716151413121110);
        check("strobe_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
